// File: rtl/tff_bank_seq_if.sv
// tff_bank_seq_if
//  Groups the command, feedback and status signals that pass between the
//  TFF-bank sequencer and the rest of the lab setup (buttons, switches and
//  the bank of T flip-flops itself).
//
//  Signals
//   start, pause, step, stop   control levels/pulses from the operator side
//   dir                        0 = count up, 1 = count down
//   load, load_val             request to load load_val into the bank
//   limit                      terminal value for counting
//   q_fb                       Q outputs read back from the TFF bank
//   t_out                      T inputs driven into the TFF bank
//   busy, done                 registered status flags
//
//  Modports
//   master  the operator/bank side: drives commands and q_fb, reads status
//   slave   the sequencer: reads commands and q_fb, drives t_out and status
interface tff_bank_seq_if #(
    parameter int N = 4
);
    logic         start;
    logic         pause;
    logic         step;
    logic         stop;
    logic         dir;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] limit;
    logic [N-1:0] q_fb;
    logic [N-1:0] t_out;
    logic         busy;
    logic         done;

    modport master (
        output start, pause, step, stop, dir, load, load_val, limit, q_fb,
        input  t_out, busy, done
    );

    modport slave (
        input  start, pause, step, stop, dir, load, load_val, limit, q_fb,
        output t_out, busy, done
    );
endinterface

// File: rtl/tff_bank_seq.sv
// tff_bank_seq
//  Sequencer for an external bank of N T flip-flops. By choosing the T input
//  of every bit from the bank's own Q read-back, it turns the bank into a
//  loadable up/down counter with start, pause, single-step and a terminal
//  count stop. The bank shares clk and rst with this block.
//
//  Ports
//   clk   in  system clock, all state changes on the rising edge
//   rst   in  synchronous active-high reset
//   bus   slave modport of tff_bank_seq_if (commands, q_fb, t_out, status)
module tff_bank_seq #(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    tff_bank_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] t_next;
    logic [N-1:0] count_t;
    logic         up_acc;
    logic         dn_acc;
    logic         at_limit;
    logic         busy_q;
    logic         done_q;

    // Toggle pattern for one count step in the current direction. Bit i
    // toggles when all lower bits are 1 (up) or all lower bits are 0 (down);
    // the running AND avoids variable-width slices.
    always_comb begin
        count_t = '0;
        up_acc  = 1'b1;
        dn_acc  = 1'b1;
        for (int i = 0; i < N; i++) begin
            count_t[i] = bus.dir ? dn_acc : up_acc;
            up_acc     = up_acc & bus.q_fb[i];
            dn_acc     = dn_acc & ~bus.q_fb[i];
        end
    end

    assign at_limit = (bus.q_fb == bus.limit);

    // Next-state and T outputs. Every branch starts from "hold": T=0 so the
    // bank keeps its value unless a load or a count is explicitly applied.
    // The priority stop > load > pause > start/step is the same everywhere,
    // and the terminal check is made before any toggle is driven.
    always_comb begin
        state_next = state;
        t_next     = '0;
        if (bus.stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load)
                        state_next = LOAD;
                    else if (!bus.pause && bus.start)
                        state_next = RUN;
                end
                LOAD: begin
                    t_next     = bus.q_fb ^ bus.load_val;
                    state_next = IDLE;
                end
                RUN: begin
                    if (bus.load)
                        state_next = LOAD;
                    else if (bus.pause)
                        state_next = PAUSE;
                    else if (at_limit)
                        state_next = DONE;
                    else
                        t_next = count_t;
                end
                PAUSE: begin
                    if (bus.load) begin
                        state_next = LOAD;
                    end else if (bus.pause) begin
                        state_next = PAUSE;
                    end else if (bus.start) begin
                        state_next = RUN;
                    end else if (bus.step) begin
                        if (at_limit)
                            state_next = DONE;
                        else
                            t_next = count_t;
                    end
                end
                DONE: begin
                    if (bus.load)
                        state_next = LOAD;
                    else if (!bus.pause && bus.start && !at_limit)
                        state_next = RUN;
                end
                default: state_next = IDLE;
            endcase
        end
        // Reset overrides everything, including the T outputs, so the bank
        // sees no toggle request while it is being cleared.
        if (rst) begin
            state_next = IDLE;
            t_next     = '0;
        end
    end

    // State register plus status flags registered from the next state, so
    // busy/done describe the state the controller is in after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == LOAD) || (state_next == RUN) ||
                      (state_next == PAUSE);
            done_q <= (state_next == DONE);
        end
    end

    assign bus.t_out = t_next;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_tff_bank_seq.sv
// tb_tff_bank_seq
//  Drives the sequencer together with a four-bit behavioural TFF bank and
//  checks T outputs, bank contents and status flags against hand-derived
//  expectations queued as each cycle's stimulus is applied.
module tb_tff_bank_seq;

    localparam int N = 4;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_RST   = 7'b1000000;
    localparam logic [6:0] C_STOP  = 7'b0100000;
    localparam logic [6:0] C_LOAD  = 7'b0010000;
    localparam logic [6:0] C_PAUSE = 7'b0001000;
    localparam logic [6:0] C_START = 7'b0000100;
    localparam logic [6:0] C_STEP  = 7'b0000010;
    localparam logic [6:0] C_DIR   = 7'b0000001;

    typedef struct {
        string    tag;
        logic [3:0] q;
        logic     busy;
        logic     done;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] bank_q;
    exp_t         sb[$];
    int           vectors;
    int           miscompares;

    tff_bank_seq_if #(.N(N)) bus ();

    tff_bank_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock generation, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Four T flip-flops sharing clk and rst with the sequencer.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst)
                bank_q[i] <= 1'b0;
            else
                bank_q[i] <= bank_q[i] ^ bus.t_out[i];
        end
    end

    assign bus.q_fb = bank_q;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check T (unless
    // exp_t_val is negative), queue the post-edge expectation, then pop and
    // compare it one time unit after the rising edge.
    task automatic applyStimulus(input string tag, input logic [6:0] cmd,
                                 input logic [3:0] lval, input logic [3:0] lim,
                                 input int exp_t_val, input logic [3:0] exp_q,
                                 input logic exp_b, input logic exp_d);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst          = cmd[6];
        bus.stop     = cmd[5];
        bus.load     = cmd[4];
        bus.pause    = cmd[3];
        bus.start    = cmd[2];
        bus.step     = cmd[1];
        bus.dir      = cmd[0];
        bus.load_val = lval;
        bus.limit    = lim;
        #1;
        if (exp_t_val >= 0)
            checkOutput({tag, " t_out"}, int'(bus.t_out), exp_t_val);
        e.tag  = tag;
        e.q    = exp_q;
        e.busy = exp_b;
        e.done = exp_d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput({got.tag, " q"},    int'(bank_q),   int'(got.q));
        checkOutput({got.tag, " busy"}, int'(bus.busy), int'(got.busy));
        checkOutput({got.tag, " done"}, int'(bus.done), int'(got.done));
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.stop     = 1'b0;
        bus.load     = 1'b0;
        bus.pause    = 1'b0;
        bus.start    = 1'b0;
        bus.step     = 1'b0;
        bus.dir      = 1'b0;
        bus.load_val = '0;
        bus.limit    = '0;

        // Reset for two cycles.
        applyStimulus("rst0", C_RST, 4'h0, 4'hF, 0, 4'h0, 1'b0, 1'b0);
        applyStimulus("rst1", C_RST, 4'h0, 4'hF, 0, 4'h0, 1'b0, 1'b0);

        // Load 0101: busy for the LOAD cycle, Q valid two edges after load.
        applyStimulus("ld5a", C_LOAD, 4'h5, 4'hF, 0,  4'h0, 1'b1, 1'b0);
        applyStimulus("ld5b", C_NONE, 4'h5, 4'hF, 5,  4'h5, 1'b0, 1'b0);
        applyStimulus("ld5c", C_NONE, 4'h5, 4'hF, 0,  4'h5, 1'b0, 1'b0);

        // Load 0000, count up to limit 0011 and stop there.
        applyStimulus("ld0a", C_LOAD,  4'h0, 4'h3, 0, 4'h5, 1'b1, 1'b0);
        applyStimulus("ld0b", C_NONE,  4'h0, 4'h3, 5, 4'h0, 1'b0, 1'b0);
        applyStimulus("up0",  C_START, 4'h0, 4'h3, 0, 4'h0, 1'b1, 1'b0);
        applyStimulus("up1",  C_START, 4'h0, 4'h3, 1, 4'h1, 1'b1, 1'b0);
        applyStimulus("up2",  C_START, 4'h0, 4'h3, 3, 4'h2, 1'b1, 1'b0);
        applyStimulus("up3",  C_START, 4'h0, 4'h3, 1, 4'h3, 1'b1, 1'b0);
        applyStimulus("upT",  C_START, 4'h0, 4'h3, 0, 4'h3, 1'b0, 1'b1);
        applyStimulus("upH",  C_START, 4'h0, 4'h3, 0, 4'h3, 1'b0, 1'b1);
        applyStimulus("upI",  C_NONE,  4'h0, 4'h3, 0, 4'h3, 1'b0, 1'b1);

        // Load 0010 from DONE, count down through zero to limit 1111.
        applyStimulus("ld2a", C_LOAD,          4'h2, 4'hF, 0,  4'h3, 1'b1, 1'b0);
        applyStimulus("ld2b", C_NONE,          4'h2, 4'hF, 1,  4'h2, 1'b0, 1'b0);
        applyStimulus("dn0",  C_START | C_DIR, 4'h2, 4'hF, 0,  4'h2, 1'b1, 1'b0);
        applyStimulus("dn1",  C_START | C_DIR, 4'h2, 4'hF, 3,  4'h1, 1'b1, 1'b0);
        applyStimulus("dn2",  C_START | C_DIR, 4'h2, 4'hF, 1,  4'h0, 1'b1, 1'b0);
        applyStimulus("dnW",  C_START | C_DIR, 4'h2, 4'hF, 15, 4'hF, 1'b1, 1'b0);
        applyStimulus("dnT",  C_START | C_DIR, 4'h2, 4'hF, 0,  4'hF, 1'b0, 1'b1);

        // Load 0011, run to 0100, pause, single-step, then resume.
        applyStimulus("ld3a", C_LOAD,  4'h3, 4'hF, 0,  4'hF, 1'b1, 1'b0);
        applyStimulus("ld3b", C_NONE,  4'h3, 4'hF, 12, 4'h3, 1'b0, 1'b0);
        applyStimulus("ps0",  C_START, 4'h3, 4'hF, 0,  4'h3, 1'b1, 1'b0);
        applyStimulus("ps1",  C_START, 4'h3, 4'hF, 7,  4'h4, 1'b1, 1'b0);
        applyStimulus("psP",  C_PAUSE, 4'h3, 4'hF, 0,  4'h4, 1'b1, 1'b0);
        applyStimulus("psH",  C_NONE,  4'h3, 4'hF, 0,  4'h4, 1'b1, 1'b0);
        applyStimulus("st1",  C_STEP,  4'h3, 4'hF, 1,  4'h5, 1'b1, 1'b0);
        applyStimulus("st2",  C_STEP,  4'h3, 4'hF, 3,  4'h6, 1'b1, 1'b0);
        applyStimulus("st3",  C_STEP,  4'h3, 4'hF, 1,  4'h7, 1'b1, 1'b0);
        applyStimulus("rs0",  C_START, 4'h3, 4'hF, 0,  4'h7, 1'b1, 1'b0);
        applyStimulus("rs1",  C_START, 4'h3, 4'hF, 15, 4'h8, 1'b1, 1'b0);

        // Load 0110 mid-run, start, then stop+load together keeps Q.
        applyStimulus("ld6a", C_LOAD,           4'h6, 4'hF, 0,  4'h8, 1'b1, 1'b0);
        applyStimulus("ld6b", C_NONE,           4'h6, 4'hF, 14, 4'h6, 1'b0, 1'b0);
        applyStimulus("sl0",  C_START,          4'h6, 4'hF, 0,  4'h6, 1'b1, 1'b0);
        applyStimulus("slS",  C_STOP | C_LOAD,  4'h6, 4'hF, 0,  4'h6, 1'b0, 1'b0);
        applyStimulus("slI",  C_NONE,           4'h6, 4'hF, 0,  4'h6, 1'b0, 1'b0);

        // Reset during RUN clears bank and returns to IDLE.
        applyStimulus("rr0",  C_START,         4'h6, 4'hF, 0, 4'h6, 1'b1, 1'b0);
        applyStimulus("rr1",  C_START,         4'h6, 4'hF, 1, 4'h7, 1'b1, 1'b0);
        applyStimulus("rrR",  C_RST | C_START, 4'h6, 4'hF, 0, 4'h0, 1'b0, 1'b0);
        applyStimulus("rrI",  C_NONE,          4'h6, 4'hF, 0, 4'h0, 1'b0, 1'b0);

        // Up wrap 1111 -> 0000, terminal at 0001, then raise limit and restart.
        applyStimulus("lfa",  C_LOAD,  4'hF, 4'h1, 0,  4'h0, 1'b1, 1'b0);
        applyStimulus("lfb",  C_NONE,  4'hF, 4'h1, 15, 4'hF, 1'b0, 1'b0);
        applyStimulus("uw0",  C_START, 4'hF, 4'h1, 0,  4'hF, 1'b1, 1'b0);
        applyStimulus("uwW",  C_START, 4'hF, 4'h1, 15, 4'h0, 1'b1, 1'b0);
        applyStimulus("uw1",  C_START, 4'hF, 4'h1, 1,  4'h1, 1'b1, 1'b0);
        applyStimulus("uwT",  C_START, 4'hF, 4'h1, 0,  4'h1, 1'b0, 1'b1);
        applyStimulus("dr0",  C_START, 4'hF, 4'h2, 0,  4'h1, 1'b1, 1'b0);
        applyStimulus("dr1",  C_START, 4'hF, 4'h2, 3,  4'h2, 1'b1, 1'b0);
        applyStimulus("drT",  C_START, 4'hF, 4'h2, 0,  4'h2, 1'b0, 1'b1);

        // Step at the limit while paused goes to DONE without toggling.
        applyStimulus("pl0",  C_LOAD,  4'h2, 4'h2, 0, 4'h2, 1'b1, 1'b0);
        applyStimulus("pl1",  C_NONE,  4'h2, 4'h2, 0, 4'h2, 1'b0, 1'b0);
        applyStimulus("pl2",  C_START, 4'h2, 4'h7, 0, 4'h2, 1'b1, 1'b0);
        applyStimulus("plP",  C_PAUSE, 4'h2, 4'h7, 0, 4'h2, 1'b1, 1'b0);
        applyStimulus("plS",  C_STEP,  4'h2, 4'h2, 0, 4'h2, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
